// File: rtl/dr_arb_pkg.sv
// Shared types and default sizing for the data-register access arbiter.
// Optional feature macro used by the top: DR_ARB_LOCK_EN.
package dr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam int          DR_NUM_REQ   = 4;
  localparam int          DR_DW        = 32;
  localparam logic [31:0] DR_RESET_VAL = 32'h0000ABCD;
  localparam int          DR_CNT_W     = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first valid requester found searching ptr, ptr+1, ... mod N.
// Purely combinational; i_ptr is assumed to be below N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0]  w_hit;
  logic [PW-1:0] w_cand [N];

  // Candidate gi is the requester gi steps after the pointer; ptr+gi < 2N so one wrap suffices.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [PW:0] w_sum;
    logic [PW:0] w_mod;
    assign w_sum       = {1'b0, i_ptr} + (PW+1)'(gi);
    assign w_mod       = (w_sum >= (PW+1)'(N)) ? (w_sum - (PW+1)'(N)) : w_sum;
    assign w_cand[gi]  = w_mod[PW-1:0];
    assign w_hit[gi]   = i_valid[w_cand[gi]];
  end

  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    o_grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_idx = w_cand[i];
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/dr_access_arbiter.sv
// Owns the shared data register and serialises round-robin read/write accesses to it.
// Define DR_ARB_LOCK_EN to add req_lock_i, letting a winner keep priority for its next request.
module dr_access_arbiter
  import dr_arb_pkg::*;
#(
  parameter int            NUM_REQ   = DR_NUM_REQ,
  parameter int            DW        = DR_DW,
  parameter logic [DW-1:0] RESET_VAL = DW'(DR_RESET_VAL),
  parameter int            CNT_W     = DR_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [NUM_REQ*DW-1:0] req_wdata_i,
`ifdef DR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock_i,
`endif
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]         rsp_rdata_o,
  output logic [DW-1:0]         dr_q_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      access_cnt_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               r_state;
  logic [DW-1:0]        r_dr_q;
  logic [DW-1:0]        r_rsp_rdata;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_winner;
  logic                 r_lock;
  logic [CNT_W-1:0]     r_cnt;

  logic [NUM_REQ-1:0]   w_grant;
  logic [PW-1:0]        w_idx;
  logic                 w_any;
  logic [DW-1:0]        w_wdata_sel;
  logic                 w_we_sel;
  logic                 w_lock_sel;
  logic [PW-1:0]        w_next_ptr;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_wdata_sel = req_wdata_i[w_idx*DW +: DW];
  assign w_we_sel    = req_we_i[w_idx];

`ifdef DR_ARB_LOCK_EN
  assign w_lock_sel = req_lock_i[w_idx];
`else
  assign w_lock_sel = 1'b0;
`endif

  // A locked winner keeps the pointer on itself so it wins again if still requesting.
  assign w_next_ptr = r_lock ? r_winner
                    : (r_winner == PW'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

  assign req_ready_o  = (r_state == ST_IDLE && rst_ni) ? w_grant : '0;
  // Reset during the response cycle must suppress the strobe that is already registered.
  assign rsp_valid_o  = r_rsp_valid & {NUM_REQ{rst_ni}};
  assign rsp_rdata_o  = r_rsp_rdata;
  assign dr_q_o       = r_dr_q;
  assign busy_o       = (r_state != ST_IDLE);
  assign access_cnt_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_dr_q      <= RESET_VAL;
      r_rsp_rdata <= '0;
      r_rsp_valid <= '0;
      r_ptr       <= '0;
      r_winner    <= '0;
      r_lock      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_winner    <= w_idx;
            r_lock      <= w_lock_sel;
            r_rsp_valid <= w_grant;
            r_rsp_rdata <= w_we_sel ? w_wdata_sel : r_dr_q;
            if (w_we_sel) r_dr_q <= w_wdata_sel;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_rsp_valid <= '0;
          r_cnt       <= r_cnt + 1'b1;
          r_ptr       <= w_next_ptr;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dr_access_arbiter.sv
// Scoreboard bench for dr_access_arbiter: a cycle-level reference model predicts grants and
// responses; a separate monitor pops expected responses whenever the DUT strobes rsp_valid_o.
module tb_dr_access_arbiter;

  localparam int          N    = 4;
  localparam int          DW   = 32;
  localparam int          CW   = 4;
  localparam logic [31:0] RVAL = 32'h0000ABCD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, dr_q;
  logic          busy;
  logic [CW-1:0] cnt;
`ifdef DR_ARB_LOCK_EN
  logic [N-1:0]  req_lock;
`endif

  always #5 clk = ~clk;

  dr_access_arbiter #(
    .NUM_REQ   (N),
    .DW        (DW),
    .RESET_VAL (RVAL),
    .CNT_W     (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_we_i     (req_we),
    .req_wdata_i  (req_wdata),
`ifdef DR_ARB_LOCK_EN
    .req_lock_i   (req_lock),
`endif
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .dr_q_o       (dr_q),
    .busy_o       (busy),
    .access_cnt_o (cnt)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference model state: a busy flag, pointer, register value and access count.
  bit            m_known = 1'b0;
  bit            m_busy  = 1'b0;
  bit            m_lock  = 1'b0;
  int            m_ptr   = 0;
  int            m_win   = 0;
  int            m_cnt   = 0;
  logic [DW-1:0] m_dr;
  logic [N-1:0]  m_acc   = '0;

  bit            pend_v  [N];
  bit            pend_we [N];
  bit            pend_lk [N];
  logic [DW-1:0] pend_d  [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: evaluated once per cycle, after inputs settle and before the next rising edge.
  initial begin
    int            win;
    logic [N-1:0]  exp_ready;
    bit            lk;
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        if (m_known) check("ready_in_reset", req_ready, '0);
        if (m_busy && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        m_busy  = 1'b0;
        m_lock  = 1'b0;
        m_ptr   = 0;
        m_win   = 0;
        m_cnt   = 0;
        m_dr    = RVAL;
        m_acc   = '0;
        m_known = 1'b1;
      end else if (m_known) begin
        check("busy", busy, m_busy);
        check("dr_q", dr_q, m_dr);
        check("access_cnt", cnt, m_cnt);
        win       = -1;
        exp_ready = '0;
        if (!m_busy) begin
          for (int i = 0; i < N; i++) begin
            if (win < 0 && req_valid[(m_ptr + i) % N]) win = (m_ptr + i) % N;
          end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        check("ready", req_ready, exp_ready);
        m_acc = '0;
        if (m_busy) begin
          m_cnt  = (m_cnt + 1) % (1 << CW);
          m_ptr  = m_lock ? m_win : (m_win + 1) % N;
          m_busy = 1'b0;
        end else if (win >= 0) begin
          lk = 1'b0;
`ifdef DR_ARB_LOCK_EN
          lk = req_lock[win];
`endif
          m_win  = win;
          m_lock = lk;
          if (req_we[win]) m_dr = req_wdata[win*DW +: DW];
          exp_q.push_back('{win, m_dr, cyc + 1});
          m_busy     = 1'b1;
          m_acc[win] = 1'b1;
        end
      end
    end
  end

  // Monitor: consumes one expectation per observed response strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid != '0) begin
        check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected cycle %0d: got rsp_valid %b expected none", cyc, rsp_valid);
        end else begin
          e = exp_q.pop_front();
          check("rsp_idx", rsp_valid, 64'(1 << e.idx));
          check("rsp_data", rsp_rdata, e.data);
          check("rsp_cycle", cyc, e.cyc);
          $display("rsp cycle %0d: requester %0d data %h", cyc, e.idx, rsp_rdata);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_missing cycle %0d: got no rsp expected requester %0d", cyc, exp_q[0].idx);
        exp_q.delete(0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) if (m_acc[k]) pend_v[k] = 1'b0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]            = pend_v[k];
      req_we[k]               = pend_we[k];
      req_wdata[k*DW +: DW]   = pend_d[k];
`ifdef DR_ARB_LOCK_EN
      req_lock[k]             = pend_lk[k];
`endif
    end
  endtask

  task automatic issue(input int k, input bit we, input logic [DW-1:0] d, input bit lk);
    pend_v[k]  = 1'b1;
    pend_we[k] = we;
    pend_d[k]  = d;
    pend_lk[k] = lk;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      drive();
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    drive();
    step();
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      pend_v[k] = 1'b0; pend_we[k] = 1'b0; pend_lk[k] = 1'b0; pend_d[k] = '0;
    end
    drive();
    run(3);

    // Single read after reset returns the reset value.
    step();
    rst_n = 1'b1;
    issue(0, 1'b0, '0, 1'b0);
    drive();
    run(3);

    // Write from requester 1, then read back through requester 2.
    step();
    issue(1, 1'b1, 32'h12345678, 1'b0);
    drive();
    run(3);
    #3 check("dr_q_after_write", dr_q, 32'h12345678);
    step();
    issue(2, 1'b0, '0, 1'b0);
    drive();
    run(3);

    // All requesters continuously valid from ptr 0.
    do_reset();
    repeat (12) begin
      step();
      for (int k = 0; k < N; k++) if (!pend_v[k]) issue(k, 1'b0, '0, 1'b0);
      drive();
    end
    step();
    for (int k = 0; k < N; k++) pend_v[k] = 1'b0;
    drive();
    run(3);

    // Reset lands in the response cycle of a write.
    step();
    issue(3, 1'b1, 32'hDEADBEEF, 1'b0);
    drive();
    step();
    rst_n = 1'b0;
    drive();
    step();
    rst_n = 1'b1;
    drive();
    #3;
    check("dr_q_after_resp_reset", dr_q, RVAL);
    check("cnt_after_resp_reset", cnt, '0);
    run(2);

`ifdef DR_ARB_LOCK_EN
    // Locked requester 0 keeps winning against requester 1, then releases.
    do_reset();
    repeat (10) begin
      step();
      if (!pend_v[0]) issue(0, 1'b0, '0, 1'b1);
      if (!pend_v[1]) issue(1, 1'b0, '0, 1'b0);
      drive();
    end
    repeat (6) begin
      step();
      if (!pend_v[0]) issue(0, 1'b0, '0, 1'b0);
      if (!pend_v[1]) issue(1, 1'b0, '0, 1'b0);
      drive();
    end
    step();
    for (int k = 0; k < N; k++) pend_v[k] = 1'b0;
    drive();
    run(3);
`endif

    // Randomised traffic with withdrawals and occasional resets.
    repeat (800) begin
      step();
      rst_n = ($urandom_range(0, 149) != 0);
      for (int k = 0; k < N; k++) begin
        if (!pend_v[k]) begin
          if ($urandom_range(0, 2) == 0)
            issue(k, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 15) == 0) begin
          pend_v[k] = 1'b0;
        end
      end
      drive();
    end

    step();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) pend_v[k] = 1'b0;
    drive();
    run(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
